// File: rtl/jk_seq_driver.sv
// JK flop-bank sequencer: converts accepted targets into one-cycle J/K excitation pulses.
// Optional feedback check of q_fb against the shadow state is enabled by JK_SEQ_DRIVER_CHECK_EN.
module jk_seq_driver #(
    parameter int unsigned WIDTH      = 4,
    parameter bit          USE_TOGGLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             err,
    output logic [7:0]       err_cnt
);

`ifdef JK_SEQ_DRIVER_CHECK_EN
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
`else
    typedef enum logic {IDLE, DRIVE} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
    logic [WIDTH-1:0] exc_j, exc_k;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (tgt_valid) state_d = DRIVE;
`ifdef JK_SEQ_DRIVER_CHECK_EN
            DRIVE: state_d = CHECK;
            CHECK: state_d = IDLE;
`else
            DRIVE: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tgt_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
    end

    // Excitation is registered at accept so j/k never see tgt_data combinationally.
    always_comb begin
        if (USE_TOGGLE) begin
            exc_j = shadow_q ^ tgt_data;
            exc_k = shadow_q ^ tgt_data;
        end else begin
            exc_j = ~shadow_q & tgt_data;
            exc_k = shadow_q & ~tgt_data;
        end
    end

`ifdef JK_SEQ_DRIVER_CHECK_EN
    logic       err_q, err_d;
    logic [7:0] cnt_q, cnt_d;
`endif

    always_comb begin
        tgt_d    = tgt_q;
        shadow_d = shadow_q;
        j_d      = '0;
        k_d      = '0;
`ifdef JK_SEQ_DRIVER_CHECK_EN
        err_d    = err_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d = tgt_data;
                    j_d   = exc_j;
                    k_d   = exc_k;
                end
            end
            DRIVE: shadow_d = tgt_q;
`ifdef JK_SEQ_DRIVER_CHECK_EN
            CHECK: begin
                if (q_fb != shadow_q) begin
                    err_d    = 1'b1;
                    shadow_d = q_fb;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q    <= '0;
            shadow_q <= '0;
            j_q      <= '0;
            k_q      <= '0;
        end else begin
            tgt_q    <= tgt_d;
            shadow_q <= shadow_d;
            j_q      <= j_d;
            k_q      <= k_d;
        end
    end

    assign j = j_q;
    assign k = k_q;

`ifdef JK_SEQ_DRIVER_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = cnt_q;
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign err         = 1'b0;
    assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_jk_seq_driver.sv
// Directed bench for jk_seq_driver: a plain-encoding and a toggle-encoding instance share stimulus,
// each looped back through a JK flop-bank model; expectations adapt to JK_SEQ_DRIVER_CHECK_EN.
module tb_jk_seq_driver;

`ifdef JK_SEQ_DRIVER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int PER = CHK ? 3 : 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tgt_valid;
    logic [3:0] tgt_data;
    logic       force_mis;

    logic       rdy1, busy1, err1, rdy2, busy2, err2;
    logic [3:0] j1, k1, j2, k2, bank1, bank2, q_fb1, q_fb2;
    logic [7:0] cnt1, cnt2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jk_seq_driver #(.WIDTH(4), .USE_TOGGLE(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy1),
        .tgt_data(tgt_data), .j(j1), .k(k1), .q_fb(q_fb1),
        .busy(busy1), .err(err1), .err_cnt(cnt1)
    );

    jk_seq_driver #(.WIDTH(4), .USE_TOGGLE(1'b1)) u_dut_tgl (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_ready(rdy2),
        .tgt_data(tgt_data), .j(j2), .k(k2), .q_fb(q_fb2),
        .busy(busy2), .err(err2), .err_cnt(cnt2)
    );

    // JK flop banks: Q+ = J&~Q | ~K&Q, reset to 0 with the driver.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank1 <= 4'b0000;
            bank2 <= 4'b0000;
        end else begin
            bank1 <= (j1 & ~bank1) | (~k1 & bank1);
            bank2 <= (j2 & ~bank2) | (~k2 & bank2);
        end
    end
    assign q_fb1 = force_mis ? 4'b0000 : bank1;
    assign q_fb2 = bank2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rdy1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    // Returns #1 after the accepting edge, i.e. inside DRIVE.
    task automatic send(input logic [3:0] d);
        bit ok = 1'b0;
        @(negedge clk);
        tgt_valid = 1'b1;
        tgt_data  = d;
        for (int n = 0; n < 10; n++) begin
            if (rdy1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        tgt_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] shadow_m, d, t;
        int         phase, accepts;
        bit         acc;

        rst_n     = 1'b0;
        tgt_valid = 1'b0;
        tgt_data  = 4'b0000;
        force_mis = 1'b0;

        // Reset state
        #3;
        check("rst_j", j1, 4'b0000);
        check("rst_k", k1, 4'b0000);
        check("rst_busy", busy1, 0);
        check("rst_ready", rdy1, 1);
        check("rst_err", err1, 0);
        check("rst_cnt", cnt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", rdy1, 1);

        // Scenario 1 / 2
        send(4'b1010);
        check("s1a_j", j1, 4'b1010);
        check("s1a_k", k1, 4'b0000);
        check("s1a_ready", rdy1, 0);
        check("s1a_busy", busy1, 1);
        check("s1a_tj", j2, 4'b1010);
        check("s1a_tk", k2, 4'b1010);
        @(posedge clk); #1;
        check("s1a_j_clr", j1, 4'b0000);
        check("s1a_k_clr", k1, 4'b0000);
        wait_idle();
        send(4'b0110);
        check("s1b_j", j1, 4'b0100);
        check("s1b_k", k1, 4'b1000);
        check("s2_tj", j2, 4'b1100);
        check("s2_tk", k2, 4'b1100);
        @(posedge clk); #1;
        check("s2_tj_clr", j2, 4'b0000);
        check("s2_tk_clr", k2, 4'b0000);
        wait_idle();

        // Equal target still passes through DRIVE with zero drive
        send(4'b0110);
        check("eq_j", j1, 4'b0000);
        check("eq_k", k1, 4'b0000);
        check("eq_busy", busy1, 1);
        wait_idle();

        // Scenario 3: valid held high, data changing every cycle
        shadow_m = 4'b0110;
        phase    = 0;
        accepts  = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            d         = 4'((i * 5 + 3) & 15);
            tgt_valid = 1'b1;
            tgt_data  = d;
            check("s3_ready", rdy1, (phase == 0) ? 1 : 0);
            acc   = (phase == 0);
            phase = (phase + 1) % PER;
            @(posedge clk); #1;
            if (acc) begin
                accepts++;
                check("s3_j", j1, ~shadow_m & d);
                check("s3_k", k1, shadow_m & ~d);
                shadow_m = d;
            end
        end
        tgt_valid = 1'b0;
        check("s3_accepts", accepts, 12 / PER);
        wait_idle();

        // Scenario 4: asynchronous reset mid-DRIVE
        do_reset();
        send(4'b1111);
        check("s4_j_pre", j1, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("s4_j_async", j1, 4'b0000);
        check("s4_k_async", k1, 4'b0000);
        check("s4_busy_async", busy1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'b0001);
        check("s4_j", j1, 4'b0001);
        check("s4_k", k1, 4'b0000);
        wait_idle();

        // Scenario 5: forced feedback mismatch
        do_reset();
        force_mis = 1'b1;
        send(4'b0011);
        check("s5_j", j1, 4'b0011);
        wait_idle();
        force_mis = 1'b0;
        check("s5_err", err1, CHK ? 1 : 0);
        check("s5_cnt", cnt1, CHK ? 1 : 0);
        send(4'b0011);
        check("s5_j_reload", j1, CHK ? 4'b0011 : 4'b0000);
        wait_idle();
        check("s5_cnt_match", cnt1, CHK ? 1 : 0);
        force_mis = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(4'b0011);
            wait_idle();
        end
        force_mis = 1'b0;
        check("s5_cnt_sat", cnt1, CHK ? 255 : 0);
        check("s5_err_sticky", err1, CHK ? 1 : 0);

        // Scenario 6: loop-back with random targets
        do_reset();
        for (int i = 0; i < 20; i++) begin
            t = 4'($urandom_range(0, 15));
            send(t);
            @(posedge clk); #1;
            check("s6_qfb", q_fb1, t);
            wait_idle();
        end
        check("s6_err", err1, 0);
        check("s6_cnt", cnt1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
